// File: rtl/nerf_pipe_pkg.sv
// Shared constants and types for the NERF host pipe endpoints.
`timescale 1ns/1ps
package nerf_pipe_pkg;

    localparam int          PIPE_W              = 16;
    localparam logic [15:0] FILL_WORD           = 16'hFFFF;
    localparam int          DEFAULT_BLOCK_WORDS = 256;
    localparam int          DEFAULT_DEPTH_LOG2  = 10;
    localparam int          BLK_CNT_W           = 9;

    typedef enum logic [0:0] {
        BLK_IDLE   = 1'b0,
        BLK_ACTIVE = 1'b1
    } blk_state_e;

endpackage

// File: rtl/gray_ptr_sync.sv
// Carries a binary FIFO pointer into another clock domain as Gray code
// and returns both the synchronised Gray value and its binary decode.
`timescale 1ns/1ps
module gray_ptr_sync #(
    parameter int W = 11
) (
    input  logic         src_clk_i,
    input  logic         src_rst_i,
    input  logic [W-1:0] bin_d_i,
    output logic [W-1:0] gray_o,
    input  logic         dst_clk_i,
    input  logic         dst_rst_i,
    output logic [W-1:0] sync_gray_o,
    output logic [W-1:0] sync_bin_o
);

    logic [W-1:0] gray_q;
    logic [W-1:0] gray_d;
    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    // Registered Gray copy built from the next-state pointer so it tracks the live pointer.
    always_comb begin
        gray_d = bin_d_i ^ (bin_d_i >> 1'b1);
    end

    always_ff @(posedge src_clk_i or posedge src_rst_i) begin
        if (src_rst_i) begin
            gray_q <= '0;
        end else begin
            gray_q <= gray_d;
        end
    end

    // Two-stage synchroniser in the destination domain.
    always_ff @(posedge dst_clk_i or posedge dst_rst_i) begin
        if (dst_rst_i) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= gray_q;
            sync_q <= meta_q;
        end
    end

    always_comb begin
        sync_bin_o = '0;
        for (int i = 0; i < W; i++) begin
            sync_bin_o[i] = ^(sync_q >> i);
        end
    end

    assign gray_o      = gray_q;
    assign sync_gray_o = sync_q;

endmodule

// File: rtl/spike_pipe_out_buffer.sv
// Spike-ID readback FIFO: captures IDs on neuron_clk and serves them to an
// okBTPipeOut endpoint on ti_clk with block-throttled ready.
`timescale 1ns/1ps
module spike_pipe_out_buffer
    import nerf_pipe_pkg::*;
#(
    parameter int DEPTH_LOG2  = DEFAULT_DEPTH_LOG2,
    parameter int BLOCK_WORDS = DEFAULT_BLOCK_WORDS,
    parameter int ID_W        = PIPE_W
) (
    input  logic                  ti_clk,
    input  logic                  neuron_clk,
    input  logic                  reset_global,
    input  logic                  enable,
    input  logic                  spike_in,
    input  logic [ID_W-1:0]       spike_id,
    input  logic                  pipe_read,
    output logic [ID_W-1:0]       pipe_data,
    output logic                  pipe_ready,
    output logic [DEPTH_LOG2:0]   fill_level,
    output logic [15:0]           drop_cnt,
    output logic                  underflow
);

    localparam int                     PW       = DEPTH_LOG2 + 1;
    localparam int                     DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [BLK_CNT_W-1:0]   BLK_LAST = BLK_CNT_W'(BLOCK_WORDS - 1);
    localparam logic [PW-1:0]          BLK_FILL = PW'(BLOCK_WORDS);

    logic [1:0]      wrst_q;
    logic [1:0]      rrst_q;
    logic            wrst_s;
    logic            rrst_s;

    logic [ID_W-1:0] mem_q [DEPTH];

    logic [PW-1:0]   wptr_q, wptr_d, wgray_s, rgray_sync_s, rptr_sync_bin_s, full_cmp_s;
    logic            full_s, push_s, drop_s;
    logic [15:0]     drop_cnt_q, drop_cnt_d;

    logic [PW-1:0]   rptr_q, rptr_d, rgray_s, wgray_sync_s, wptr_sync_bin_s;
    logic [PW-1:0]   fill_q, fill_d;
    logic            empty_s, pop_s;
    logic            underflow_q, underflow_d;
    logic [ID_W-1:0] pipe_data_q;

    blk_state_e             state_q, state_d;
    logic [BLK_CNT_W-1:0]   blk_cnt_q, blk_cnt_d;
    logic                   ready_q, ready_d;

    logic            unused_rptr_bin_s;

    // Per-domain reset: asserts immediately, releases after two local clock edges.
    always_ff @(posedge neuron_clk or posedge reset_global) begin
        if (reset_global) begin
            wrst_q <= 2'b11;
        end else begin
            wrst_q <= {wrst_q[0], 1'b0};
        end
    end

    always_ff @(posedge ti_clk or posedge reset_global) begin
        if (reset_global) begin
            rrst_q <= 2'b11;
        end else begin
            rrst_q <= {rrst_q[0], 1'b0};
        end
    end

    assign wrst_s = wrst_q[1];
    assign rrst_s = rrst_q[1];

    gray_ptr_sync #(.W(PW)) u_wptr_sync (
        .src_clk_i   (neuron_clk),
        .src_rst_i   (wrst_s),
        .bin_d_i     (wptr_d),
        .gray_o      (wgray_s),
        .dst_clk_i   (ti_clk),
        .dst_rst_i   (rrst_s),
        .sync_gray_o (wgray_sync_s),
        .sync_bin_o  (wptr_sync_bin_s)
    );

    gray_ptr_sync #(.W(PW)) u_rptr_sync (
        .src_clk_i   (ti_clk),
        .src_rst_i   (rrst_s),
        .bin_d_i     (rptr_d),
        .gray_o      (rgray_s),
        .dst_clk_i   (neuron_clk),
        .dst_rst_i   (wrst_s),
        .sync_gray_o (rgray_sync_s),
        .sync_bin_o  (rptr_sync_bin_s)
    );

    assign unused_rptr_bin_s = ^rptr_sync_bin_s;

    // Write controller: full when the pointers differ by exactly one lap.
    always_comb begin
        full_cmp_s = {~rgray_sync_s[PW-1:PW-2], rgray_sync_s[PW-3:0]};
        full_s     = (wgray_s == full_cmp_s);
        push_s     = enable & spike_in & ~full_s;
        drop_s     = enable & spike_in & full_s;
        wptr_d     = wptr_q + {{(PW-1){1'b0}}, push_s};
        if (drop_s && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end else begin
            drop_cnt_d = drop_cnt_q;
        end
    end

    always_ff @(posedge neuron_clk or posedge wrst_s) begin
        if (wrst_s) begin
            wptr_q     <= '0;
            drop_cnt_q <= 16'd0;
        end else begin
            wptr_q     <= wptr_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    always_ff @(posedge neuron_clk) begin
        if (push_s) begin
            mem_q[wptr_q[DEPTH_LOG2-1:0]] <= spike_id;
        end
    end

    // Read controller; occupancy uses the post-read pointer so it is exact after each edge.
    always_comb begin
        empty_s     = (rgray_s == wgray_sync_s);
        pop_s       = pipe_read & ~empty_s;
        rptr_d      = rptr_q + {{(PW-1){1'b0}}, pop_s};
        fill_d      = wptr_sync_bin_s - rptr_d;
        underflow_d = underflow_q | (pipe_read & empty_s);
    end

    always_ff @(posedge ti_clk or posedge rrst_s) begin
        if (rrst_s) begin
            rptr_q      <= '0;
            fill_q      <= '0;
            underflow_q <= 1'b0;
            pipe_data_q <= '0;
        end else begin
            rptr_q      <= rptr_d;
            fill_q      <= fill_d;
            underflow_q <= underflow_d;
            if (pop_s) begin
                pipe_data_q <= mem_q[rptr_q[DEPTH_LOG2-1:0]];
            end else if (pipe_read) begin
                pipe_data_q <= FILL_WORD;
            end else begin
                pipe_data_q <= pipe_data_q;
            end
        end
    end

    // Block counter: ready holds for a whole block once the host starts reading it.
    always_comb begin
        state_d   = state_q;
        blk_cnt_d = blk_cnt_q;
        ready_d   = 1'b0;
        case (state_q)
            BLK_IDLE: begin
                if (pipe_read && ready_q) begin
                    state_d   = BLK_ACTIVE;
                    blk_cnt_d = 9'd1;
                    ready_d   = 1'b1;
                end else begin
                    ready_d   = (fill_q >= BLK_FILL);
                end
            end
            BLK_ACTIVE: begin
                ready_d = 1'b1;
                if (pipe_read) begin
                    if (blk_cnt_q == BLK_LAST) begin
                        state_d   = BLK_IDLE;
                        blk_cnt_d = 9'd0;
                        ready_d   = 1'b0;
                    end else begin
                        blk_cnt_d = blk_cnt_q + 9'd1;
                    end
                end else begin
                    blk_cnt_d = blk_cnt_q;
                end
            end
            default: begin
                state_d   = BLK_IDLE;
                blk_cnt_d = 9'd0;
                ready_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge ti_clk or posedge rrst_s) begin
        if (rrst_s) begin
            state_q   <= BLK_IDLE;
            blk_cnt_q <= 9'd0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            blk_cnt_q <= blk_cnt_d;
            ready_q   <= ready_d;
        end
    end

    assign pipe_data  = pipe_data_q;
    assign pipe_ready = ready_q;
    assign fill_level = fill_q;
    assign drop_cnt   = drop_cnt_q;
    assign underflow  = underflow_q;

endmodule

// File: tb/tb_spike_pipe_out_buffer.sv
// Directed bench for spike_pipe_out_buffer: a vector table of write/read
// phases plus hand sequences for underflow, concurrent traffic and mid-block reset.
`timescale 1ns/1ps
module tb_spike_pipe_out_buffer;

    localparam int BW    = 256;
    localparam int DEPTH = 1024;

    logic        ti_clk       = 1'b0;
    logic        neuron_clk   = 1'b0;
    logic        reset_global = 1'b0;
    logic        enable       = 1'b0;
    logic        spike_in     = 1'b0;
    logic [15:0] spike_id     = 16'd0;
    logic        pipe_read    = 1'b0;
    logic [15:0] pipe_data;
    logic        pipe_ready;
    logic [10:0] fill_level;
    logic [15:0] drop_cnt;
    logic        underflow;

    realtime n_half = 500.0;
    int      n_checks = 0;
    int      n_fail   = 0;
    int      next_id  = 0;
    int      model_q[$];

    typedef struct {
        bit rst;
        bit fast;
        int wr_n;
        int rd_blocks;
        int exp_fill;
        bit exp_ready;
        int exp_drop;
        bit exp_uf;
    } vec_t;

    vec_t vecs[9];

    spike_pipe_out_buffer dut (
        .ti_clk       (ti_clk),
        .neuron_clk   (neuron_clk),
        .reset_global (reset_global),
        .enable       (enable),
        .spike_in     (spike_in),
        .spike_id     (spike_id),
        .pipe_read    (pipe_read),
        .pipe_data    (pipe_data),
        .pipe_ready   (pipe_ready),
        .fill_level   (fill_level),
        .drop_cnt     (drop_cnt),
        .underflow    (underflow)
    );

    always #10.417 ti_clk = ~ti_clk;
    always #(n_half) neuron_clk = ~neuron_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d (0x%0h), expected %0d (0x%0h)", name, $time, act, act, exp, exp);
        end
    endtask

    task automatic release_reset();
        reset_global = 1'b0;
        repeat (3) @(posedge neuron_clk);
        repeat (3) @(posedge ti_clk);
        model_q.delete();
        next_id = 0;
    endtask

    task automatic do_reset();
        pipe_read    = 1'b0;
        spike_in     = 1'b0;
        reset_global = 1'b1;
        #100;
        release_reset();
    endtask

    task automatic write_spikes(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge neuron_clk);
            enable   = 1'b1;
            spike_in = 1'b1;
            spike_id = 16'(next_id);
            if (model_q.size() < DEPTH) model_q.push_back(next_id);
            next_id++;
        end
        @(negedge neuron_clk);
        spike_in = 1'b0;
    endtask

    task automatic read_words(input int n, input bit chk_ready);
        int exp;
        @(negedge ti_clk);
        pipe_read = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(posedge ti_clk);
            #1;
            if (i == n - 1) pipe_read = 1'b0;
            exp = (model_q.size() > 0) ? model_q.pop_front() : 32'h0000FFFF;
            check("pipe_data", 32'(pipe_data), exp);
            if (chk_ready && i < n - 1) check("pipe_ready_hold", 32'(pipe_ready), 32'd1);
        end
    endtask

    task automatic wait_ready();
        int k;
        k = 0;
        while (pipe_ready !== 1'b1 && k < 5000) begin
            @(negedge ti_clk);
            k++;
        end
        check("pipe_ready_rise", 32'(pipe_ready), 32'd1);
    endtask

    task automatic settle();
        repeat (3) @(posedge neuron_clk);
        repeat (8) @(posedge ti_clk);
        @(negedge ti_clk);
    endtask

    task automatic check_status(input int fill, input bit rdy, input int drop, input bit uf);
        check("fill_level", 32'(fill_level), fill);
        check("pipe_ready", 32'(pipe_ready), 32'(rdy));
        check("drop_cnt",   32'(drop_cnt),   drop);
        check("underflow",  32'(underflow),  32'(uf));
    endtask

    task automatic run_vec(input int v);
        n_half = vecs[v].fast ? 31.25 : 500.0;
        if (vecs[v].rst) do_reset();
        if (vecs[v].wr_n > 0) write_spikes(vecs[v].wr_n);
        settle();
        for (int b = 0; b < vecs[v].rd_blocks; b++) begin
            wait_ready();
            read_words(BW, 1'b1);
        end
        settle();
        check_status(vecs[v].exp_fill, vecs[v].exp_ready, vecs[v].exp_drop, vecs[v].exp_uf);
    endtask

    initial begin
        //            rst   fast  wr    rd  fill  ready drop uf
        vecs[0] = '{1'b1, 1'b0, 300,  0, 300,  1'b1, 0, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 0,    1, 44,   1'b0, 0, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 1030, 0, 1024, 1'b1, 6, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 0,    4, 0,    1'b0, 6, 1'b0};
        vecs[4] = '{1'b1, 1'b1, 256,  1, 0,    1'b0, 0, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 256,  1, 0,    1'b0, 0, 1'b0};
        vecs[6] = '{1'b0, 1'b1, 256,  1, 0,    1'b0, 0, 1'b0};
        vecs[7] = '{1'b0, 1'b1, 256,  1, 0,    1'b0, 0, 1'b0};
        vecs[8] = '{1'b0, 1'b1, 256,  1, 0,    1'b0, 0, 1'b0};

        #5;
        do_reset();
        @(negedge ti_clk);
        check("rst_pipe_data", 32'(pipe_data), 32'd0);
        check_status(0, 1'b0, 0, 1'b0);

        // basic and overflow phases
        for (int v = 0; v < 4; v++) run_vec(v);

        // underflow: three reads of an empty FIFO
        for (int p = 0; p < 3; p++) begin
            @(negedge ti_clk);
            pipe_read = 1'b1;
            @(posedge ti_clk);
            #1;
            pipe_read = 1'b0;
            check("underflow_data", 32'(pipe_data), 32'h0000FFFF);
            repeat (2) @(posedge ti_clk);
        end
        @(negedge ti_clk);
        check("underflow_sticky", 32'(underflow), 32'd1);
        check("underflow_fill", 32'(fill_level), 32'd0);
        write_spikes(1);
        settle();
        read_words(1, 1'b0);
        settle();
        check("post_underflow_fill", 32'(fill_level), 32'd0);

        // pointer wrap phases
        for (int v = 4; v < 9; v++) run_vec(v);

        // concurrent writes during a block read
        write_spikes(BW);
        settle();
        wait_ready();
        fork
            write_spikes(50);
            read_words(BW, 1'b1);
        join
        settle();
        check("concurrent_fill", 32'(fill_level), 32'd50);
        read_words(50, 1'b0);
        settle();
        check_status(0, 1'b0, 0, 1'b0);

        // reset in the middle of a block
        write_spikes(BW);
        settle();
        wait_ready();
        read_words(100, 1'b1);
        reset_global = 1'b1;
        #1;
        check("midrst_pipe_data", 32'(pipe_data), 32'd0);
        check_status(0, 1'b0, 0, 1'b0);
        #100;
        release_reset();
        write_spikes(BW);
        settle();
        wait_ready();
        read_words(BW, 1'b1);
        settle();
        check_status(0, 1'b0, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
